fetch_top: RTL

Instruction-fetch stage of the etcpu five-stage pipeline: owns the program counter, issues word requests to instruction memory over a request/grant + in-order response interface, buffers returned words, and drives the IF/ID register (`if_inst`, `if_pc`) consumed by decode. Honours decode's `bubble` by holding the IF/ID register. Honours execute's control-flow redirect by flushing the buffer, dropping in-flight responses and restarting at the target.

---
 rtl/utils_top_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/fetch_top.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/utils_top_pkg.sv
// rtl/utils_top_pkg.sv - shared fetch-stage constants, state enum and buffer entry type
package utils_top;

  localparam int                INST_W   = 32;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    FS_BOOT,
    FS_RUN,
    FS_FLUSH
  } fetch_state_t;

  // One buffered instruction together with the PC it was fetched from
  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous {pc, inst} buffer with push, pop, clear and occupancy
module fetch_fifo
  import utils_top::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  fetch_entry_t  push_data_i,
  input  logic          pop_i,
  input  logic          clear_i,
  output fetch_entry_t  head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;

  // Pointer and occupancy next state; clear discards contents and any same-cycle push/pop
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (clear_i) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + AW'(1);
      if (pop_i)  rd_d = rd_q + AW'(1);
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset: occupancy alone says which slots are meaningful
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop_i && empty_o && !clear_i));

endmodule

// File: rtl/fetch_top.sv
// rtl/fetch_top.sv - instruction fetch stage (PC, imem request/response, IF/ID); FETCH_PERF_CNT_EN adds perf counters
module fetch_top
  import utils_top::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bubble,
  input  logic              ex_redirect,
  input  logic [31:0]       ex_target,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] if_inst,
  output logic [31:0]       if_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall,
  output logic [31:0]       perf_flush
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  fetch_state_t      state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [CW-1:0]     out_q, out_d, drop_q, drop_d, redirect_drop;
  logic [31:0]       rq_pc_q [FIFO_DEPTH];
  logic [AW-1:0]     rq_wr_q, rq_rd_q;
  logic [INST_W-1:0] if_inst_q, if_inst_d;
  logic [31:0]       if_pc_q, if_pc_d;

  fetch_entry_t      fifo_head, resp_entry;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [CW:0]       inflight;
  logic              credit_ok, fire, resp_drop, resp_keep, direct, deliver;

  // A returning word goes straight to IF/ID when nothing is queued ahead of it,
  // which keeps one credit free and gives 1 instr/cycle with a 2-entry buffer.
  assign inflight   = {1'b0, out_q} + {1'b0, fifo_count};
  assign credit_ok  = (inflight < (CW+1)'(FIFO_DEPTH));
  assign fire       = imem_req & imem_gnt;
  assign resp_drop  = imem_rvalid & (ex_redirect | (drop_q != '0));
  assign resp_keep  = imem_rvalid & ~resp_drop;
  assign direct     = resp_keep & fifo_empty & ~bubble;
  assign fifo_push  = resp_keep & ~direct;
  assign fifo_pop   = ~ex_redirect & ~bubble & ~fifo_empty;
  assign deliver    = fifo_pop | direct;
  assign resp_entry = '{pc: rq_pc_q[rq_rd_q], inst: imem_rdata};

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (fifo_push),
    .push_data_i (resp_entry),
    .pop_i       (fifo_pop),
    .clear_i     (ex_redirect),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FS_BOOT;
    else        state_q <= state_d;
  end

  // FSM next state: redirect overrides everything, FLUSH ends when the last stale word is gone
  always_comb begin
    state_d = state_q;
    if (ex_redirect) begin
      state_d = (redirect_drop != '0) ? FS_FLUSH : FS_RUN;
    end else begin
      case (state_q)
        FS_BOOT:  state_d = FS_RUN;
        FS_FLUSH: if (drop_d == '0) state_d = FS_RUN;
        default:  state_d = state_q;
      endcase
    end
  end

  // FSM outputs: request whenever running, not redirecting and a credit is free
  always_comb begin
    imem_req  = (state_q != FS_BOOT) & ~ex_redirect & credit_ok;
    imem_addr = pc_q;
  end

  // PC, outstanding and drop counters; responses arriving with a redirect are dropped too
  always_comb begin
    redirect_drop = out_q - CW'(imem_rvalid);
    out_d         = out_q + CW'(fire) - CW'(imem_rvalid);
    pc_d          = pc_q;
    drop_d        = drop_q;
    if (ex_redirect) begin
      pc_d   = ex_target;
      drop_d = redirect_drop;
    end else begin
      if (fire) pc_d = pc_q + 32'd4;
      if (imem_rvalid && (drop_q != '0)) drop_d = drop_q - CW'(1);
    end
  end

  // IF/ID next value: redirect, then bubble hold, then buffered/returning word, else NOP
  always_comb begin
    if_inst_d = NOP_INST;
    if_pc_d   = '0;
    if (ex_redirect) begin
      if_inst_d = NOP_INST;
      if_pc_d   = '0;
    end else if (bubble) begin
      if_inst_d = if_inst_q;
      if_pc_d   = if_pc_q;
    end else if (!fifo_empty) begin
      if_inst_d = fifo_head.inst;
      if_pc_d   = fifo_head.pc;
    end else if (direct) begin
      if_inst_d = resp_entry.inst;
      if_pc_d   = resp_entry.pc;
    end
  end

  // Datapath and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      out_q     <= '0;
      drop_q    <= '0;
      rq_wr_q   <= '0;
      rq_rd_q   <= '0;
      if_inst_q <= NOP_INST;
      if_pc_q   <= '0;
    end else begin
      pc_q      <= pc_d;
      out_q     <= out_d;
      drop_q    <= drop_d;
      if (fire)        rq_wr_q <= rq_wr_q + AW'(1);
      if (imem_rvalid) rq_rd_q <= rq_rd_q + AW'(1);
      if_inst_q <= if_inst_d;
      if_pc_q   <= if_pc_d;
    end
  end

  // Request-PC queue: every response, kept or dropped, consumes the oldest entry
  always_ff @(posedge clk) begin
    if (fire) rq_pc_q[rq_wr_q] <= pc_q;
  end

  assign if_inst = if_inst_q;
  assign if_pc   = if_pc_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_stall_q, perf_flush_q;

  // Free-running wrapping event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
      perf_flush_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_q + 32'(deliver);
      perf_stall_q   <= perf_stall_q + 32'(bubble);
      perf_flush_q   <= perf_flush_q + 32'(resp_drop);
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
  assign perf_flush   = perf_flush_q;
`endif

  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rvalid && (out_q == '0)));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_push && fifo_full && !fifo_pop));

endmodule
